// File: rtl/mux2_bus_arbiter_if.sv
// rtl/mux2_bus_arbiter_if.sv - two-requester / one-consumer valid-ready bus bundle
interface mux2_bus_arbiter_if;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_src;
  logic        out_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux2_bus_arbiter.sv
// rtl/mux2_bus_arbiter.sv - round-robin arbiter sharing one registered 32-bit output channel
module mux_2x1_32 (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        select,
  output logic [31:0] out
);
  assign out = select ? in2 : in1;
endmodule

module mux2_bus_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  mux2_bus_arbiter_if.slave bus,
  output logic [CNT_W-1:0] xfer_count
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state;
  logic             last_grant;
  logic [31:0]      data_q;
  logic             src_q;
  logic [CNT_W-1:0] count_q;

  logic             grant;
  logic             any_valid;
  logic             cap;
  logic             capture;
  logic             drain;
  logic [31:0]      mux_out;

  always_comb begin
    grant = last_grant;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end else if (bus.req0_valid) begin
      grant = 1'b0;
    end
  end

  mux_2x1_32 u_mux (
    .in1    (bus.req0_data),
    .in2    (bus.req1_data),
    .select (grant),
    .out    (mux_out)
  );

  // Readies are masked during reset so nothing is accepted that reset would drop.
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign cap       = (state == EMPTY) | bus.out_ready;
  assign capture   = cap & any_valid & ~reset;
  assign drain     = (state == FULL) & bus.out_ready;

  assign bus.req0_ready = capture & bus.req0_valid & (grant == 1'b0);
  assign bus.req1_ready = capture & bus.req1_valid & (grant == 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      data_q     <= '0;
      src_q      <= 1'b0;
      last_grant <= 1'b1;
      count_q    <= '0;
    end else begin
      if (drain) begin
        count_q <= count_q + 1'b1;
      end
      if (capture) begin
        data_q     <= mux_out;
        src_q      <= grant;
        last_grant <= grant;
        state      <= FULL;
      end else if (drain) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign xfer_count    = count_q;
endmodule

// File: doc/mux2_bus_arbiter.md
Name: mux2_bus_arbiter

Overview:
- Two-requester round-robin arbiter that shares one 32-bit output channel.
- The datapath is a mux_2x1_32 instance: in1 = requester 0 data, in2 = requester 1 data, select = current grant (0 passes in1, 1 passes in2).
- Arbiter owns grant/select sequencing, valid/ready handshakes on both sides, a one-entry output holding register and a transfer counter.
- Sits in front of a shared register-write or result bus of the datapath.

Parameters:
- CNT_W, 16, width of the completed-transfer counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has data.
- req0_data  input  32  requester 0 payload.
- req0_ready  output  1  requester 0 payload accepted this cycle.
- req1_valid  input  1  requester 1 has data.
- req1_data  input  32  requester 1 payload.
- req1_ready  output  1  requester 1 payload accepted this cycle.
- out_valid  output  1  out_data holds a transfer.
- out_data  output  32  registered selected payload.
- out_src  output  1  requester id of out_data.
- out_ready  input  1  consumer accepts out_data.
- xfer_count  output  CNT_W  number of completed output handshakes.

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_data=0, out_src=0, xfer_count=0, last_grant=1 (requester 0 has first priority). All requester data not yet captured is dropped; requesters must re-present. Reset overrides every simultaneous event.
- State: EMPTY (out_valid=0) / FULL (out_valid=1).
- Capture enable: cap = (state==EMPTY) | out_ready.
- Grant (combinational):
  - Both valid: grant = ~last_grant.
  - One valid: grant = that requester.
  - Neither valid: no grant; select holds last_grant.
- Ready outputs: reqN_ready = cap & reqN_valid & (grant==N). They are combinational and never both high.
- Handshake rule: requester N's transfer completes in the cycle it sees reqN_valid & reqN_ready. Requesters must hold valid and data stable until ready.
- On a capture edge:
  - out_data <= mux output.
  - out_src <= grant.
  - last_grant <= grant.
  - out_valid <= 1.
- Latency: 1 cycle from accept to out_valid.
- Output drain: on out_valid & out_ready with no new capture, out_valid <= 0 (FULL->EMPTY).
- Output handshake counting: every cycle with out_valid & out_ready increments xfer_count by 1, wrapping from 2^CNT_W-1 to 0.
- Throughput: 1 transfer/cycle. In FULL with out_ready=1 and a pending request, the drain and the new capture happen in the same cycle; state stays FULL and xfer_count increments.
- Back-pressure: in FULL with out_ready=0, both readies are 0. out_data, out_src and out_valid hold unchanged.
- Fairness: with both requesters continuously valid, grants strictly alternate, so neither waits more than one accepted transfer.
- last_grant changes only on a capture, not on idle cycles.

Test Plan:
- Reset, then req0_valid=1 with data 0xDEADBEEF, out_ready=1 -> req0_ready=1 in cycle 0; next cycle out_valid=1, out_data=0xDEADBEEF, out_src=0; xfer_count=1 after the handshake.
- Both valid (req0 0x11111111, req1 0x22222222 each held until accepted, then deasserted), out_ready=1 from reset -> accepts req0 then req1 on consecutive cycles; outputs 0x11111111 (src 0) then 0x22222222 (src 1); no idle cycle between them.
- Both valid continuously for 8 cycles, out_ready=1 -> out_src sequence 0,1,0,1,0,1,0,1; xfer_count=8.
- FULL with out_ready=0 for 5 cycles while req1 valid -> req1_ready stays 0, out_data stable; on out_ready=1, req1 is accepted the same cycle and appears next cycle.
- Assert reset while FULL with req0 valid -> next cycle out_valid=0, xfer_count=0, both readies 0 during reset; after release, req0 (first priority) is accepted first.
- CNT_W=2, 5 back-to-back transfers -> xfer_count reads 1,2,3,0,1.
